seq_chunk_adder: RTL
====================

# seq_chunk_adder

Parametrised multi-cycle adder. It adds two WIDTH-bit operands plus carry-in by iterating a CHUNK-bit ripple adder LSB-first, one chunk per clock, and reports the result with a start/done handshake. It is the successor to the fixed 4-bit full adder: any width, area traded for latency, and registered, handshaked results for use by datapath sequencers.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of CHUNK.
- CHUNK, 4: bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while idle.
- A  in  WIDTH  operand A; captured on the accepting edge.
- B  in  WIDTH  operand B; captured on the accepting edge.
- Cin  in  1  carry-in; captured on the accepting edge.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse; Sum/Cout valid.
- Sum  out  WIDTH  result; held until the next done.
- Cout  out  1  carry out of bit WIDTH-1; held with Sum.
- Ovf  out  1  signed overflow; present only with ADDER_OVF_EN.

## Operation
- NCHUNK = WIDTH/CHUNK. Chunk index k is a counter of width clog2(NCHUNK), minimum 1.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Transitions:
  - IDLE → RUN on start=1. On that edge, latch A, B and Cin into internal registers, clear k and the partial sum, and set carry=Cin.
  - RUN, each edge: add bits [k*CHUNK +: CHUNK] of the latched operands plus carry. Write the chunk result into the partial sum, update carry, and increment k.
  - RUN → IDLE on the edge that processes k=NCHUNK-1. On that same edge:
    - load the partial sum into Sum;
    - load the final carry into Cout;
    - set done=1.
- done returns to 0 on the next edge, unconditionally.
- start while busy=1 is ignored: no queueing and no effect on the operation in flight.
- A, B and Cin may change freely after acceptance; only the latched copies are used.
- Sum and Cout change only on the done edge. They are never visible in a partial state.
- Arithmetic is unsigned, modulo 2^WIDTH. Cout is the true carry out.
- Reset (any time, including mid-RUN):
  - state → IDLE, k → 0;
  - busy, done, Cout and Ovf → 0;
  - Sum → 0;
  - the partial sum is discarded; there is no pending done after reset.

## Timing
- start sampled high at edge T0 (state IDLE): busy=1 after T0.
- done=1 and the result are visible after edge T0+NCHUNK. busy=0 at the same point.
- Latency is NCHUNK cycles. The defaults give 4.
- Degenerate case WIDTH=CHUNK: latency 1. The state still passes through RUN for one cycle.
- Back-to-back operation: start high during the done cycle is accepted, because state is IDLE. Throughput is then one result per NCHUNK+1 cycles at most. Sum and Cout of the previous result hold until the next done.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- ADDER_OVF_EN defined:
  - adds the Ovf port, registered;
  - Ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), captured from the last chunk on the done edge;
  - Ovf holds with Sum;
  - requires the per-chunk adder to also expose its MSB carry-in.
- ADDER_OVF_EN undefined: the Ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package adder_pkg:
  - state typedef (IDLE, RUN);
  - clog2 helper function;
  - parameter-legality check constants (WIDTH % CHUNK == 0). An illegal configuration is a fatal elaboration error.
- One sub-module, fa_chunk:
  - combinational CHUNK-bit ripple adder built from full-adder cells;
  - ports: a, b, cin, sum, cout, c_msb (carry into the MSB, for overflow).
- The top level holds the FSM, counter, operand registers and result registers.

## Test plan
All cases use WIDTH=16, CHUNK=4 unless stated.

1. A=0x0006, B=0x0004, Cin=0, start pulse → busy for 4 cycles; done after T0+4; Sum=0x000A, Cout=0, Ovf=0.
2. A=0xFFFF, B=0x0001, Cin=0 → Sum=0x0000, Cout=1, Ovf=0. Also A=0x8000, B=0x9000, Cin=1 → Sum=0x1001, Cout=1, Ovf=1.
3. A=0x7FFF, B=0x0000, Cin=1 → Sum=0x8000, Cout=0, Ovf=1. Change A/B every cycle during RUN → result unaffected.
4. Start 0x1234+0x1111. Re-assert start with 0xFFFF+0xFFFF at T0+2 → ignored. Exactly one done, at T0+4, with Sum=0x2345. Assert start again in the done cycle → accepted; second done at T0+9.
5. Start an operation and drop rst_n at T0+2, asynchronously between edges → busy, done, Sum and Cout read 0 immediately. No done is produced after release. A fresh start then completes normally in 4 cycles.
6. Sweep WIDTH/CHUNK in {8/8, 8/1, 32/8} with random operands → Sum/Cout match the reference sum. Latency equals WIDTH/CHUNK.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the sequential chunk adder.
//   state_t        : FSM state encoding (IDLE, RUN)
//   clog2_min1()   : ceil(log2(n)), never less than 1, for counter widths
//   chunk_cfg_ok() : legality of a WIDTH/CHUNK pair
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // CHUNK must divide WIDTH so the last chunk ends exactly on bit WIDTH-1.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/fa_chunk.sv
// fa_chunk: combinational CHUNK-bit ripple-carry adder built from full-adder cells.
//   a, b   : CHUNK-bit operands
//   cin    : carry into bit 0
//   sum    : CHUNK-bit result
//   cout   : carry out of the MSB
//   c_msb  : carry into the MSB (present only when ADDER_OVF_EN is defined)
module fa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             c_msb
`endif
);

  // c[i] is the carry into bit i; c[CHUNK] is the carry out.
  logic [CHUNK:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
    end
  endgenerate

  assign cout = c[CHUNK];

`ifdef ADDER_OVF_EN
  assign c_msb = c[CHUNK-1];
`endif

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit adder, CHUNK bits per clock, LSB first.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : request, sampled only while idle
//   A, B, Cin  : operands, captured on the accepting edge
//   busy       : high while an addition is in progress
//   done       : one-cycle pulse when Sum/Cout (and Ovf) are updated
//   Sum, Cout  : registered result, held until the next done
//   Ovf        : signed overflow, only when ADDER_OVF_EN is defined
// Optional feature macro: ADDER_OVF_EN.
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = clog2_min1(NCHUNK);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  generate
    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $fatal(1, "seq_chunk_adder: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [KW-1:0]    k_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] psum_reg, psum_next;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg, cout_reg, done_reg;
  logic             accept, last;

  logic [CHUNK-1:0] a_chunk, b_chunk, chunk_sum;
  logic             chunk_cout;
`ifdef ADDER_OVF_EN
  logic             chunk_c_msb;
  logic             ovf_reg;
`endif

  assign a_chunk = a_reg[int'(k_reg)*CHUNK +: CHUNK];
  assign b_chunk = b_reg[int'(k_reg)*CHUNK +: CHUNK];

  fa_chunk #(.CHUNK(CHUNK)) u_fa_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_reg),
    .sum  (chunk_sum),
    .cout (chunk_cout)
`ifdef ADDER_OVF_EN
    ,
    .c_msb(chunk_c_msb)
`endif
  );

  // Next state plus the two edge qualifiers: accept (IDLE->RUN) and
  // last (the edge that processes the final chunk).
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        if (k_reg == K_LAST) begin
          state_next = IDLE;
          last       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Partial sum with the current chunk merged in; on the last edge this is
  // the complete result, so Sum loads it directly.
  always_comb begin
    psum_next = psum_reg;
    psum_next[int'(k_reg)*CHUNK +: CHUNK] = chunk_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      psum_reg  <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef ADDER_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      done_reg  <= last;
      if (accept) begin
        a_reg     <= A;
        b_reg     <= B;
        carry_reg <= Cin;
        k_reg     <= '0;
        psum_reg  <= '0;
      end else if (state_reg == RUN) begin
        psum_reg  <= psum_next;
        carry_reg <= chunk_cout;
        k_reg     <= last ? '0 : k_reg + 1'b1;
      end
      if (last) begin
        sum_reg  <= psum_next;
        cout_reg <= chunk_cout;
`ifdef ADDER_OVF_EN
        ovf_reg  <= chunk_c_msb ^ chunk_cout;
`endif
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign Sum  = sum_reg;
  assign Cout = cout_reg;
`ifdef ADDER_OVF_EN
  assign Ovf  = ovf_reg;
`endif

endmodule
